// File: rtl/decrypt_pkg.sv
// Shared types and constants for the decrypt datapath: FSM state encoding,
// default widths and the rotation amount the encryptor applied.
package decrypt_pkg;

  localparam int DATA_W_DEF = 4;
  localparam int ADDR_W_DEF = 4;
  localparam int ROT_AMT    = 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FETCH  = 2'd1,
    DIVIDE = 2'd2,
    FINISH = 2'd3
  } state_e;

endpackage

// File: rtl/decrypt_unit_if.sv
// Request/status bundle of decrypt_unit plus the memory read port it shares.
// Handshake: start is a single-cycle request that is accepted only when busy=0;
// done pulses for one cycle with error/num_out valid, which then hold until the
// next accepted start. mem_rdata is combinational from mem_addr.
interface decrypt_unit_if #(
  parameter int DATA_W = decrypt_pkg::DATA_W_DEF,
  parameter int ADDR_W = decrypt_pkg::ADDR_W_DEF
) ();

  logic                  start;
  logic [ADDR_W-1:0]     addr;
  logic [DATA_W-1:0]     key;
  logic [ADDR_W-1:0]     mem_addr;
  logic [2*DATA_W-1:0]   mem_rdata;
  logic                  busy;
  logic                  done;
  logic                  error;
  logic [DATA_W-1:0]     num_out;

  modport slave (
    input  start, addr, key, mem_rdata,
    output mem_addr, busy, done, error, num_out
  );

  modport master (
    output start, addr, key, mem_rdata,
    input  mem_addr, busy, done, error, num_out
  );

endinterface

// File: rtl/decrypt_unit_div_step.sv
// One restoring-division step: shift the next dividend bit into the partial
// remainder and subtract the divisor when it fits.
module div_step #(
  parameter int W = decrypt_pkg::DATA_W_DEF
) (
  input  logic [W:0]   rem_in,
  input  logic         dividend_msb,
  input  logic [W-1:0] divisor,
  output logic [W:0]   rem_out,
  output logic         q_bit
);

  logic [W+1:0] shifted;
  logic [W:0]   diff;

  always_comb begin
    shifted = {rem_in, dividend_msb};
    q_bit   = (shifted >= {2'b00, divisor});
    diff    = shifted[W:0] - {1'b0, divisor};
    rem_out = q_bit ? diff : shifted[W:0];
  end

endmodule

// File: rtl/decrypt_unit.sv
// Decrypt unit: fetch ciphertext, restoring-divide by key, undo the rotation.
// Define DECRYPT_REM_CHECK_EN to reject ciphertext leaving a non-zero remainder.
module decrypt_unit
  import decrypt_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic           clock,
  input  logic           reset_n,
  decrypt_unit_if.slave  bus,
  output state_e         dbg_state_o
);

  localparam int CW    = 2 * DATA_W;
  localparam int CNT_W = $clog2(CW + 1);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   key_q;
  logic [CW-1:0]       div_q;
  logic [DATA_W:0]     rem_q;
  logic [CW-1:0]       quot_q;
  logic [CNT_W-1:0]    cnt_q;
  logic                done_q;
  logic                error_q;
  logic [DATA_W-1:0]   num_q;

  logic                accept, load, step, finish, busy;
  logic [DATA_W:0]     rem_nxt;
  logic                q_bit;
  logic                error_d;
  logic [DATA_W-1:0]   num_d;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bus.start) state_d = FETCH;
      FETCH:   state_d = DIVIDE;
      DIVIDE:  if (cnt_q == CNT_W'(1)) state_d = FINISH;
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    accept = (state_q == IDLE) && bus.start;
    load   = (state_q == FETCH);
    step   = (state_q == DIVIDE);
    finish = (state_q == FINISH);
    busy   = (state_q != IDLE);
  end

  div_step #(.W(DATA_W)) u_div_step (
    .rem_in       (rem_q),
    .dividend_msb (div_q[CW-1]),
    .divisor      (key_q),
    .rem_out      (rem_nxt),
    .q_bit        (q_bit)
  );

  // key==0 yields an all-ones quotient; it is flagged here, not special-cased.
  always_comb begin
    error_d = (key_q == '0) || (quot_q[CW-1:DATA_W] != '0);
`ifdef DECRYPT_REM_CHECK_EN
    error_d = error_d || (rem_q != '0);
`endif
    num_d = error_d ? '0
                    : {quot_q[DATA_W-ROT_AMT-1:0], quot_q[DATA_W-1:DATA_W-ROT_AMT]};
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      addr_q  <= '0;
      key_q   <= '0;
      div_q   <= '0;
      rem_q   <= '0;
      quot_q  <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
      num_q   <= '0;
    end else begin
      done_q <= finish;
      if (accept) begin
        addr_q  <= bus.addr;
        key_q   <= bus.key;
        error_q <= 1'b0;
        num_q   <= '0;
      end
      if (load) begin
        div_q  <= bus.mem_rdata;
        rem_q  <= '0;
        quot_q <= '0;
        cnt_q  <= CNT_W'(CW);
      end
      if (step) begin
        div_q  <= div_q << 1;
        rem_q  <= rem_nxt;
        quot_q <= {quot_q[CW-2:0], q_bit};
        cnt_q  <= cnt_q - CNT_W'(1);
      end
      if (finish) begin
        error_q <= error_d;
        num_q   <= num_d;
      end
    end
  end

  assign bus.mem_addr = addr_q;
  assign bus.busy     = busy;
  assign bus.done     = done_q;
  assign bus.error    = error_q;
  assign bus.num_out  = num_q;
  assign dbg_state_o  = state_q;

endmodule

// File: doc/decrypt_unit.md
Name: decrypt_unit

Overview:
- Inverse of the encrypt datapath (register → rotate-right ×2 → multiply by key → store in 16×8 memory).
- Takes a memory address and key on a start pulse, fetches the stored 8-bit ciphertext through a read port, and runs a sequential restoring division by the key.
- Undoes the double rotation and returns the original 4-bit number with done/error status.
- Sits beside the encrypt datapath and shares the memory's read side.

Parameters:
- DATA_W, 4, plaintext/key width; ciphertext width is 2*DATA_W.
- ADDR_W, 4, memory address width (16 locations).

Ports:
- clock  input  1  sole clock, rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- start  input  1  request pulse; sampled only in IDLE.
- addr  input  ADDR_W  location of the ciphertext; captured on start.
- key  input  DATA_W  decryption key; captured on start.
- mem_addr  output  ADDR_W  read address to memory.
- mem_rdata  input  2*DATA_W  combinational read data from memory.
- busy  output  1  high from the accepting edge until done.
- done  output  1  one-cycle pulse; result valid.
- error  output  1  valid with done; held until next accepted start.
- num_out  output  DATA_W  decrypted number; held until next accepted start.

Behaviour:
- Reset (asynchronous, any state, including mid-division):
  - state=IDLE; busy, done, error, num_out, mem_addr, all internal registers = 0.
  - Any in-flight operation is discarded; no done pulse follows.
- States: IDLE → FETCH → DIVIDE → FINISH → IDLE.
- IDLE:
  - start=1 at edge E0 captures addr into mem_addr and key into key_r.
  - busy=1, done=0, error=0 at E0; go to FETCH.
- FETCH (one cycle):
  - At E1 capture mem_rdata into dividend register, clear partial remainder (DATA_W+1 bits), quotient=0, iteration count=2*DATA_W.
  - Go to DIVIDE.
- DIVIDE (2*DATA_W = 8 cycles, edges E2..E9), each cycle one restoring step:
  - Shift {rem, dividend} left by 1.
  - If rem ≥ key_r: rem -= key_r and shift 1 into quotient, else shift 0.
  - Decrement count; at 0 go to FINISH.
- FINISH (edge E10):
  - error = (key_r==0) OR (quotient[2*DATA_W-1:DATA_W] != 0) [overflow] (OR remainder check, see Optional Feature).
  - num_out = error ? 0 : rotate-left-by-2 of quotient[DATA_W-1:0], i.e. {q[1:0], q[3:2]}.
  - done=1, busy=0 for exactly one cycle; return to IDLE.
- Latency: start edge to done edge = 10 cycles.
- Back-to-back: a start in the cycle done is high is accepted (state is IDLE).
- start while busy is ignored; no queueing.
- key=0 still runs full length, with deterministic timing and no divide-by-zero special path; error=1 at done.
- mem_addr is held stable from E0 until the next accepted start.

Optional Feature:
- Macro: DECRYPT_REM_CHECK_EN.
- Defined: a non-zero final remainder also sets error=1 (forces num_out=0), since ciphertext not produced by the encryptor is rejected.
- Undefined: the remainder is discarded; num_out = rotated truncated quotient whenever key≠0 and no overflow.

Decomposition:
- Package decrypt_pkg:
  - state enum (IDLE, FETCH, DIVIDE, FINISH);
  - DATA_W/ADDR_W defaults;
  - rotation amount constant ROT_AMT=2.
- One natural sub-module: div_step, a combinational single restoring-division step (rem_in, dividend_msb, divisor → rem_out, q_bit), instantiated once inside the sequential loop.

Test Plan:
- mem[8]=0x10, key=4'b1000, start → done at +10 cycles, num_out=4'b1000, error=0.
- mem[8]=0x30 key=4'b1000 → num_out=4'b1001; mem=0x1E key=4'b1010 → 4'b1100; mem=0xC4 key=4'b1110 → 4'b1011; all error=0.
- key=0, mem=0x10 → done at +10, error=1, num_out=0; mem=0xFF key=4'b0001 (quotient 255) → error=1 overflow.
- mem=0x1F key=4'b1010 (rem 1): with DECRYPT_REM_CHECK_EN → error=1, num_out=0; without → error=0, num_out=4'b1100.
- reset_n low at cycle 5 of DIVIDE → all outputs 0 immediately, no done; new start after release → correct result at +10.
- start re-asserted at cycles 3 and 7 while busy → ignored, single done; start in done cycle → second done exactly 10 cycles later.
